// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM states, grant kinds and the
// all-ones data returned when a transfer times out.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    GT_FETCH,
    GT_READ,
    GT_WRITE,
    GT_DMA
  } grant_e;

  // Wide enough for any supported data width; callers slice [RV-1:0].
  localparam int ERR_W = 1024;
  localparam logic [ERR_W-1:0] ERR_DATA = '1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Core, DMA and downstream memory handshakes of mem_arbiter in one bundle.
// slave = arbiter view, master = the surrounding core/DMA/memory.
interface mem_arbiter_if #(
  parameter int RV = 16,
  parameter int VA = RV
);
  localparam int AW = VA - RV/16;
  localparam int MW = RV/8;

  logic          ifetch;
  logic [1:0]    rstrobe;
  logic [MW-1:0] wmask;
  logic          io_access;
  logic [AW-1:0] addr;
  logic [RV-1:0] wdata;
  logic          idone, rdone, wdone;
  logic [RV-1:0] rdata;

  logic          dma_req, dma_we;
  logic [AW-1:0] dma_addr;
  logic [RV-1:0] dma_wdata;
  logic          dma_ack;
  logic [RV-1:0] dma_rdata;

  logic          mem_req, mem_we, mem_io;
  logic [AW-1:0] mem_addr;
  logic [RV-1:0] mem_wdata;
  logic [MW-1:0] mem_mask;
  logic          mem_ack;
  logic [RV-1:0] mem_rdata;

  logic          bus_err;

  modport slave (
    input  ifetch, rstrobe, wmask, io_access, addr, wdata,
    output idone, rdone, wdone, rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_ack, dma_rdata,
    output mem_req, mem_we, mem_io, mem_addr, mem_wdata, mem_mask,
    input  mem_ack, mem_rdata,
    output bus_err
  );

  modport master (
    output ifetch, rstrobe, wmask, io_access, addr, wdata,
    input  idone, rdone, wdone, rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_ack, dma_rdata,
    input  mem_req, mem_we, mem_io, mem_addr, mem_wdata, mem_mask,
    output mem_ack, mem_rdata,
    input  bus_err
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: req[0] = core, req[1] = DMA; gnt=1 selects DMA.
// The loser of the last grant wins the next tie; core is favoured after reset.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       upd,
  output logic       gnt,
  output logic       any
);

  logic pref_dma;

  always_comb begin
    any = |req;
    gnt = (req[0] & req[1]) ? pref_dma : req[1];
  end

  always_ff @(posedge clk) begin
    if (!reset)
      pref_dma <= 1'b0;
    else if (upd && any)
      pref_dma <= ~gnt;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates core (fetch/read/write) and DMA onto one memory port with
// round-robin fairness, a per-transfer ack timeout and a sticky error flag.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int RV  = 16,
  parameter int VA  = RV,
  parameter int TMO = 255
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int AW = VA - RV/16;
  localparam int MW = RV/8;

  typedef struct packed {
    logic          we;
    logic          io;
    logic [AW-1:0] addr;
    logic [RV-1:0] wdata;
    logic [MW-1:0] mask;
  } mreq_t;

  state_e        state;
  grant_e        grant, core_ty, nxt_ty;
  mreq_t         nxt, cur;
  logic [7:0]    cnt;
  logic          core_req, pick_dma, any_req;
  logic [RV-1:0] resp_data;

  rr_arb2 u_rr (
    .clk   (clk),
    .reset (reset),
    .req   ({bus.dma_req, core_req}),
    .upd   (state == ST_IDLE),
    .gnt   (pick_dma),
    .any   (any_req)
  );

  always_comb begin
    core_req = (|bus.wmask) | (|bus.rstrobe) | bus.ifetch;
    if (|bus.wmask)        core_ty = GT_WRITE;
    else if (|bus.rstrobe) core_ty = GT_READ;
    else                   core_ty = GT_FETCH;

    nxt       = '0;
    nxt.addr  = bus.addr;
    nxt.wdata = bus.wdata;
    nxt_ty    = core_ty;
    if (pick_dma) begin
      nxt_ty    = GT_DMA;
      nxt.we    = bus.dma_we;
      nxt.addr  = bus.dma_addr;
      nxt.wdata = bus.dma_wdata;
      nxt.mask  = '1;
    end else begin
      unique case (core_ty)
        GT_WRITE: begin nxt.we = 1'b1; nxt.io = bus.io_access; nxt.mask = bus.wmask; end
        GT_READ:  begin nxt.io = bus.io_access; nxt.mask = MW'(bus.rstrobe); end
        default:  nxt.mask = '1;
      endcase
    end

    // No ack means the count ran out: hand back the error pattern instead.
    resp_data = bus.mem_ack ? bus.mem_rdata : ERR_DATA[RV-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ST_IDLE;
      grant         <= GT_FETCH;
      cur           <= '0;
      cnt           <= '0;
      bus.mem_req   <= 1'b0;
      bus.idone     <= 1'b0;
      bus.rdone     <= 1'b0;
      bus.wdone     <= 1'b0;
      bus.dma_ack   <= 1'b0;
      bus.rdata     <= '0;
      bus.dma_rdata <= '0;
      bus.bus_err   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: if (any_req) begin
          state       <= ST_BUSY;
          grant       <= nxt_ty;
          cur         <= nxt;
          cnt         <= '0;
          bus.mem_req <= 1'b1;
        end
        ST_BUSY: begin
          // Compare before increment so the counter never wraps.
          if (bus.mem_ack || cnt == 8'(TMO)) begin
            state       <= ST_RESP;
            bus.mem_req <= 1'b0;
            if (!bus.mem_ack) bus.bus_err <= 1'b1;
            if (grant == GT_DMA) bus.dma_rdata <= resp_data;
            else                 bus.rdata     <= resp_data;
            bus.idone   <= (grant == GT_FETCH);
            bus.rdone   <= (grant == GT_READ);
            bus.wdone   <= (grant == GT_WRITE);
            bus.dma_ack <= (grant == GT_DMA);
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_RESP: begin
          state       <= ST_IDLE;
          bus.idone   <= 1'b0;
          bus.rdone   <= 1'b0;
          bus.wdone   <= 1'b0;
          bus.dma_ack <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_we    = cur.we;
  assign bus.mem_io    = cur.io;
  assign bus.mem_addr  = cur.addr;
  assign bus.mem_wdata = cur.wdata;
  assign bus.mem_mask  = cur.mask;

endmodule
